prefetch_unit: RTL and testbench

//  Parametrised successor to the single-cycle fetch stage: PC generation + instruction prefetch queue.

---
 rtl/prefetch_unit_pkg.sv | 15 +
 rtl/prefetch_unit_inst_fifo.sv | 58 +++++
 rtl/prefetch_unit.sv | 104 ++++++++++
 tb/tb_prefetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the prefetch unit: widths, reset PC, fetch FSM states.
package prefetch_unit_pkg;

  localparam int unsigned PF_XLEN     = 32;
  localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PF_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/prefetch_unit_inst_fifo.sv
// Synchronous instruction queue with flush; head is read straight from storage.
module inst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !i_flush && (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The fetch FSM reserves a slot before issuing, so a push can never meet a full queue.
  always_ff @(posedge clk) begin
    if (rst && w_push) assert (!w_full || w_pop);
  end

endmodule

// File: rtl/prefetch_unit.sv
// PC generation and prefetch queue: one outstanding req/gnt/rvalid fetch, redirect flushes.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = PF_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PF_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [XLEN-1:0]        inst_pc,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  logic            r_req;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;

  logic [XLEN-1:0]    w_redir_pc;
  logic               w_push;
  logic               w_pop;
  logic               w_room;
  logic               w_room_after;
  logic [XLEN+31:0]   w_head;

  assign w_redir_pc   = redirect_pc & ~(XLEN'(3));
  assign w_push       = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop        = inst_valid && inst_ready && !redirect_valid;
  assign w_room       = (q_count < CW'(DEPTH));
  assign w_room_after = (q_count < CW'(DEPTH - 1)) || w_pop;

  assign imem_req      = r_req;
  assign imem_addr     = r_fetch_pc;
  assign inst_valid    = (q_count != '0);
  assign {inst_pc, inst} = w_head;

  inst_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_req_pc, imem_rdata}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redir_pc;
      // With nothing in flight the flushed queue has room, so request the new PC next cycle.
      unique case (r_state)
        IDLE: begin r_state <= REQ; r_req <= 1'b1; end
        REQ:  begin
          r_state <= imem_gnt ? DROP : REQ;
          r_req   <= !imem_gnt;
        end
        WAIT: begin r_state <= imem_rvalid ? IDLE : DROP; r_req <= 1'b0; end
        DROP: begin r_state <= imem_rvalid ? IDLE : DROP; r_req <= 1'b0; end
      endcase
    end else begin
      unique case (r_state)
        IDLE: if (w_room) begin r_state <= REQ; r_req <= 1'b1; end
        REQ: if (imem_gnt) begin
          r_req_pc   <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
          r_state    <= WAIT;
          r_req      <= 1'b0;
        end
        WAIT: if (imem_rvalid) begin
          r_state <= w_room_after ? REQ : IDLE;
          r_req   <= w_room_after;
        end
        DROP: if (imem_rvalid) begin r_state <= IDLE; r_req <= 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!imem_rvalid || (r_state inside {WAIT, DROP}));
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a one-outstanding variable-latency memory model.
module tb_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  q_count;

  prefetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .q_count        (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int          mem_lat = 1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  bit          last_iss = 1'b0;

  typedef struct {
    logic        gnt;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    int unsigned e_cnt;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_bad++;
    $display("FAIL %s: timeout, got no event want event at %0t", name, $time);
  endtask

  // Advance one clock; the memory model answers each issue after mem_lat cycles.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    iss = (imem_req === 1'b1) && (imem_gnt === 1'b1);
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    last_iss    = iss;
    if (iss) begin
      check("one_outstanding", 32'(pend), 32'h0);
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = mem_lat;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(pend_addr);
        pend        = 1'b0;
      end
    end
  endtask

  // Returns at the negedge of the first cycle with imem_req high (no tick afterwards).
  task automatic wait_req(input int budget, input logic [31:0] exp_addr,
                          input bit chk_addr, input bit chk_empty);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (imem_req) begin
        if (chk_addr) check("req_addr", imem_addr, exp_addr);
        found = 1'b1;
        break;
      end
      if (chk_empty) check("empty_while_waiting", 32'(inst_valid), 32'h0);
      tick();
    end
    if (!found) timeout_fail("wait_req");
  endtask

  task automatic expect_pops(input int n, input logic [31:0] start, input int budget);
    logic [31:0] pc;
    int          got;
    pc  = start;
    got = 0;
    inst_ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        check("pop_pc", inst_pc, pc);
        check("pop_inst", inst, memword(pc));
        pc = pc + 32'd4;
        got++;
      end
      tick();
    end
    if (got < n) timeout_fail("expect_pops");
  endtask

  initial begin
    bit          found;
    logic [31:0] cap;

    //          gnt   rdy   req   addr        vld   pc          cnt
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0,      0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h4,      1'b1, 32'h0,      1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h8,      1'b1, 32'h4,      1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hC,      1'b1, 32'h8,      1};

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b1;
    tick();
    tick();
    rst = 1'b1;

    // Streaming from reset at one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      imem_gnt   = vecs[i].gnt;
      inst_ready = vecs[i].ready;
      @(negedge clk);
      check("vec_req", 32'(imem_req), 32'(vecs[i].e_req));
      check("vec_valid", 32'(inst_valid), 32'(vecs[i].e_valid));
      check("vec_count", 32'(q_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_req) check("vec_addr", imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        check("vec_pc", inst_pc, vecs[i].e_pc);
        check("vec_inst", inst, memword(vecs[i].e_pc));
      end
      tick();
    end

    // Decode stall: queue fills, fetching stops, head frozen.
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        check("stall_valid", 32'(inst_valid), 32'h1);
        check("stall_pc", inst_pc, 32'hC);
        check("stall_inst", inst, memword(32'hC));
      end
      if (i >= 8) check("stall_req", 32'(imem_req), 32'h0);
      if (i == 19) check("stall_count", 32'(q_count), 32'h4);
      tick();
    end
    expect_pops(6, 32'hC, 40);

    // Redirect from IDLE with a full queue: request the new PC the next cycle.
    inst_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    @(negedge clk);
    check("refill_count", 32'(q_count), 32'h4);
    check("refill_req", 32'(imem_req), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("idle_redir_req", 32'(imem_req), 32'h1);
    check("idle_redir_addr", imem_addr, 32'h300);
    check("idle_redir_valid", 32'(inst_valid), 32'h0);
    check("idle_redir_count", 32'(q_count), 32'h0);
    tick();

    // Redirect to 0x43 while a fetch is outstanding and the queue is non-empty.
    mem_lat = 3;
    found   = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      @(negedge clk);
      if (last_iss && q_count >= 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout_fail("reach_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wait_redir_valid", 32'(inst_valid), 32'h0);
    check("wait_redir_count", 32'(q_count), 32'h0);
    check("wait_redir_req", 32'(imem_req), 32'h0);
    tick();
    wait_req(20, 32'h40, 1'b1, 1'b1);
    tick();
    expect_pops(2, 32'h40, 20);

    // Reset in WAIT with rvalid arriving during reset.
    mem_lat = 2;
    wait_req(20, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_count", 32'(q_count), 32'h0);
    tick();
    rst = 1'b1;
    wait_req(20, 32'h0, 1'b1, 1'b1);
    tick();
    expect_pops(1, 32'h0, 20);

    // Address wrap; low redirect bits are dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    wait_req(20, 32'hFFFF_FFFC, 1'b1, 1'b1);
    tick();
    expect_pops(2, 32'hFFFF_FFFC, 20);

    // Redirect in the same cycle as req&gnt; the late response is discarded.
    mem_lat = 5;
    wait_req(20, 32'h0, 1'b0, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drop_req", 32'(imem_req), 32'h0);
      check("drop_valid", 32'(inst_valid), 32'h0);
      tick();
    end
    wait_req(20, 32'h200, 1'b1, 1'b1);
    tick();
    expect_pops(1, 32'h200, 20);

    // Grant withheld: request held stable, PC advances only when granted.
    mem_lat = 1;
    wait_req(40, 32'h0, 1'b0, 1'b0);
    cap      = imem_addr;
    imem_gnt = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      @(negedge clk);
      check("nogrant_req", 32'(imem_req), 32'h1);
      check("nogrant_addr", imem_addr, cap);
    end
    imem_gnt = 1'b1;
    tick();
    expect_pops(2, cap, 20);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
